ps_memory: RTL and testbench
============================

# ps_memory

Memory-side responder for the simple-ps processor bus: answers the processor's m_addr / m_data / m_wren requests with registered read data on m_q. It holds a 4096 x 16 synchronous RAM and two memory-mapped I/O words. It also contains a byte-stream program loader that fills the RAM from address 0 before the processor is started with exec.

## Interface

Parameters:
- ADDR_W, 12, bus address width; RAM depth is 2**ADDR_W words.
- IO_OUT_ADDR, 12'hFFF, address of the output I/O register (read/write).
- IO_IN_ADDR, 12'hFFE, address of the input I/O port (read-only).

Ports:
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- m_addr  in  ADDR_W  processor word address.
- m_data  in  16  processor write data.
- m_wren  in  1  processor write enable.
- m_q  out  16  read data, registered.
- io_in  in  16  external input word.
- io_out  out  16  output I/O register.
- ld_start  in  1  one-cycle pulse: begin program load at address 0.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte; high byte of each word first.
- ld_last  in  1  qualifies the low byte of the final word.
- ld_ready  out  1  loader may accept a byte.
- ld_done  out  1  one-cycle pulse when a load completes.
- busy  out  1  high while loading; the processor must be held (exec low).

## Operation

- States: IDLE (bus service), LOAD_HI, LOAD_LO.
- IDLE:
  - m_wren=1 with m_addr=IO_OUT_ADDR: io_out <= m_data; RAM is not written.
  - m_wren=1 with m_addr=IO_IN_ADDR: write discarded.
  - m_wren=1 at any other address: RAM[m_addr] <= m_data.
  - Read every cycle, mux by m_addr:
    - IO_OUT_ADDR -> io_out (value before any same-cycle write).
    - IO_IN_ADDR -> io_in.
    - else RAM[m_addr], read-old-data on a same-address write.
- ld_start in IDLE: load address <= 0, go to LOAD_HI. ld_start in any other state is ignored.
- LOAD_HI: ld_ready=1. On ld_valid: hold register <= ld_data, go to LOAD_LO.
- LOAD_LO: ld_ready=1. On ld_valid:
  - RAM[load address] <= {hold, ld_data}.
  - If ld_last, or load address = 2**ADDR_W-1: go to IDLE and pulse ld_done.
  - Otherwise: load address +1, go to LOAD_HI.
- Loader writes go to RAM only, including the I/O addresses' RAM locations, which are unreachable from the bus.
- During LOAD_*: processor writes are dropped, m_q holds its last value, busy=1.
- ld_last on a high byte is ignored.

## Timing

- Reset values: m_q=0, io_out=0, ld_ready=0, ld_done=0, busy=0, state IDLE, load address 0, hold 0. RAM contents are not reset.
- Read latency 1: m_q after edge N reflects m_addr sampled at edge N. The processor samples m_q on its next phase.
- Write takes effect at the sampling edge; a read of that address at the next edge returns the new data.
- Loader throughput: one byte per cycle while ld_valid is held; one word per 2 cycles.
- ld_done is high for exactly the cycle after the final LO byte is accepted; busy falls at that same edge.
- Reset mid-load: immediate return to IDLE. Words already written remain in RAM; no ld_done pulse.
- ld_valid low: state holds indefinitely, no timeout.

## Test plan

- Reset: assert reset asynchronously between edges -> m_q, io_out, busy, ld_ready all 0 immediately.
- RAM access: write 16'hBEEF to 12'h010, then read 12'h010 -> m_q=16'hBEEF one cycle after the address. Write and read 12'h011 in the same cycle -> old data returned.
- I/O: write 16'h00A5 to 12'hFFF -> io_out=16'h00A5, read 12'hFFF returns it. Drive io_in=16'h1234 and read 12'hFFE -> 16'h1234. Write to 12'hFFE -> no change anywhere.
- Load: ld_start, then bytes 12,34,56,78 with ld_last on the 4th -> RAM[0]=16'h1234, RAM[1]=16'h5678, ld_done pulse, busy low. A processor write during the load leaves its target unchanged.
- Gapped load: ld_valid toggling every other cycle -> same RAM result. ld_last asserted on a HI byte is ignored.
- Wrap and abort:
  - 4096 words without ld_last -> load ends at address 12'hFFF with ld_done.
  - Reset after 3 words -> IDLE, RAM[0..2] written, no ld_done.

Source files
------------

// File: rtl/ps_memory.sv
// Memory-side responder for the simple-ps bus: 4096x16 RAM, two I/O words,
// and a byte-stream program loader that fills RAM from address 0.
//
// state     | meaning
// S_IDLE    | bus service: reads, writes, I/O register
// S_LOAD_HI | loader waiting for the high byte of a word
// S_LOAD_LO | loader waiting for the low byte; writes the word to RAM
module ps_memory #(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = 12'hFFF,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR  = 12'hFFE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [15:0]       m_data,
  input  logic              m_wren,
  output logic [15:0]       m_q,
  input  logic [15:0]       io_in,
  output logic [15:0]       io_out,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_HI, S_LOAD_LO} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic [7:0]          hold_q, hold_d;
  logic [15:0]         m_q_q, m_q_d;
  logic [15:0]         io_out_q, io_out_d;
  logic                ld_done_q, ld_done_d;

  logic [15:0]         mem [0:(2**ADDR_W)-1];
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [15:0]         ram_wdata;
  logic [15:0]         rd_data;

  // I/O output reads return the pre-write value; RAM reads are read-old-data.
  always_comb begin
    rd_data = mem[m_addr];
    if (m_addr == IO_OUT_ADDR) begin
      rd_data = io_out_q;
    end else if (m_addr == IO_IN_ADDR) begin
      rd_data = io_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    hold_d    = hold_q;
    m_q_d     = m_q_q;
    io_out_d  = io_out_q;
    ld_done_d = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = m_addr;
    ram_wdata = m_data;
    case (state_q)
      S_IDLE: begin
        m_q_d = rd_data;
        if (m_wren) begin
          if (m_addr == IO_OUT_ADDR) begin
            io_out_d = m_data;
          end else if (m_addr != IO_IN_ADDR) begin
            ram_we = 1'b1;
          end
        end
        if (ld_start) begin
          ld_addr_d = '0;
          state_d   = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        if (ld_valid) begin
          hold_d  = ld_data;
          state_d = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (ld_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ld_addr_q;
          ram_wdata = {hold_q, ld_data};
          if (ld_last || (ld_addr_q == '1)) begin
            state_d   = S_IDLE;
            ld_done_d = 1'b1;
          end else begin
            ld_addr_d = ld_addr_q + 1'b1;
            state_d   = S_LOAD_HI;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ld_addr_q <= '0;
      hold_q    <= '0;
      m_q_q     <= '0;
      io_out_q  <= '0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      hold_q    <= hold_d;
      m_q_q     <= m_q_d;
      io_out_q  <= io_out_d;
      ld_done_q <= ld_done_d;
    end
  end

  // RAM contents are deliberately not reset so a mid-load abort keeps loaded words.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  assign m_q      = m_q_q;
  assign io_out   = io_out_q;
  assign ld_done  = ld_done_q;
  assign busy     = (state_q != S_IDLE);
  assign ld_ready = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps_memory.sv
// Self-checking bench for ps_memory: directed scenarios plus randomized bus
// traffic and loader streams compared against an array-based memory model.
module tb_ps_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] m_addr;
  logic [15:0] m_data;
  logic        m_wren;
  logic [15:0] m_q;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_data;
  logic        ld_ready, ld_done, busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem_m [0:4095];
  logic [15:0] io_m;

  ps_memory dut (
    .clock(clock), .reset(reset),
    .m_addr(m_addr), .m_data(m_data), .m_wren(m_wren), .m_q(m_q),
    .io_in(io_in), .io_out(io_out),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    m_addr = a; m_data = d; m_wren = 1'b1;
    tick();
    m_wren = 1'b0;
    if (a == 12'hFFF) io_m = d;
    else if (a != 12'hFFE) mem_m[a] = d;
  endtask

  task automatic bus_read(input logic [11:0] a, input string nm);
    logic [15:0] exp;
    exp = (a == 12'hFFF) ? io_m : (a == 12'hFFE) ? io_in : mem_m[a];
    m_addr = a; m_wren = 1'b0;
    tick();
    n_cmp++;
    if (m_q !== exp) begin
      n_err++;
      $display("FAIL %s addr=%h got=%h want=%h", nm, a, m_q, exp);
    end
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start busy/ready got=%b%b want=11", busy, ld_ready);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gap,
                           input bit final_lo);
    if (gap) begin
      ld_valid = 1'b0;
      tick();
      n_cmp++;
      if (ld_done !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL gap_hold done/busy got=%b%b want=01", ld_done, busy);
      end
    end
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ld_ready got=%b want=1", ld_ready);
    end
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++;
    if (ld_done !== final_lo || busy !== !final_lo) begin
      n_err++;
      $display("FAIL byte_done done/busy got=%b%b want=%b%b", ld_done, busy,
               final_lo, !final_lo);
    end
  endtask

  task automatic check_done_cleared();
    tick();
    n_cmp++;
    if (ld_done !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse done/busy/ready got=%b%b%b want=000",
               ld_done, busy, ld_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    bus_write(12'hFFF, 16'h5A5A);
    bus_read(12'hFFF, "pre_reset_read");
    start_load();
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (m_q !== 16'h0 || io_out !== 16'h0 || busy !== 1'b0 || ld_ready !== 1'b0 ||
        ld_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset m_q=%h io_out=%h busy=%b ready=%b done=%b want all 0",
               m_q, io_out, busy, ld_ready, ld_done);
    end
    io_m = 16'h0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ram();
    logic [15:0] old;
    bus_write(12'h010, 16'hBEEF);
    bus_read(12'h010, "ram_beef");
    bus_write(12'h011, 16'h1111);
    old = mem_m[12'h011];
    m_addr = 12'h011; m_data = 16'h2222; m_wren = 1'b1;
    tick();
    m_wren = 1'b0;
    mem_m[12'h011] = 16'h2222;
    n_cmp++;
    if (m_q !== old) begin
      n_err++;
      $display("FAIL read_old_data got=%h want=%h", m_q, old);
    end
    bus_read(12'h011, "ram_after_rw");
  endtask

  task automatic test_io();
    bus_write(12'hFFF, 16'h00A5);
    n_cmp++;
    if (io_out !== 16'h00A5) begin
      n_err++;
      $display("FAIL io_out got=%h want=00a5", io_out);
    end
    bus_read(12'hFFF, "io_out_read");
    io_in = 16'h1234;
    bus_read(12'hFFE, "io_in_read");
    bus_write(12'hFFE, 16'hDEAD);
    n_cmp++;
    if (io_out !== 16'h00A5) begin
      n_err++;
      $display("FAIL io_in_write_discard io_out got=%h want=00a5", io_out);
    end
    bus_read(12'hFFE, "io_in_after_write");
    bus_read(12'h010, "ram_after_io_write");
  endtask

  task automatic test_random_bus();
    logic [11:0] a;
    logic [15:0] d, exp;
    logic        w;
    for (int i = 0; i < 16; i++) bus_write(12'h020 + 12'(i), 16'($urandom));
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 12'hFFF;
        1:       a = 12'hFFE;
        default: a = 12'h020 + 12'($urandom_range(0, 15));
      endcase
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      io_in = 16'($urandom);
      exp = (a == 12'hFFF) ? io_m : (a == 12'hFFE) ? io_in : mem_m[a];
      m_addr = a; m_data = d; m_wren = w;
      tick();
      if (w) begin
        if (a == 12'hFFF) io_m = d;
        else if (a != 12'hFFE) mem_m[a] = d;
      end
      n_cmp++;
      if (m_q !== exp || io_out !== io_m) begin
        n_err++;
        $display("FAIL rand_bus i=%0d addr=%h m_q=%h want=%h io_out=%h want=%h",
                 i, a, m_q, exp, io_out, io_m);
      end
    end
    m_wren = 1'b0;
  endtask

  task automatic test_load();
    logic [15:0] held;
    bus_read(12'h020, "pre_load_read");
    held = mem_m[12'h020];
    start_load();
    m_addr = 12'h021; m_data = 16'hFFFF; m_wren = 1'b1;
    send_byte(8'h12, 1'b0, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0, 1'b0);
    send_byte(8'h78, 1'b1, 1'b0, 1'b1);
    m_wren = 1'b0;
    n_cmp++;
    if (m_q !== held) begin
      n_err++;
      $display("FAIL m_q_hold got=%h want=%h", m_q, held);
    end
    mem_m[0] = 16'h1234;
    mem_m[1] = 16'h5678;
    check_done_cleared();
    bus_read(12'h000, "load_w0");
    bus_read(12'h001, "load_w1");
    bus_read(12'h021, "dropped_write");
  endtask

  task automatic test_gapped_load();
    logic [15:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
    start_load();
    send_byte(w[0][15:8], 1'b0, 1'b1, 1'b0);
    send_byte(w[0][7:0],  1'b0, 1'b1, 1'b0);
    send_byte(w[1][15:8], 1'b1, 1'b1, 1'b0);
    send_byte(w[1][7:0],  1'b0, 1'b1, 1'b0);
    send_byte(w[2][15:8], 1'b0, 1'b1, 1'b0);
    send_byte(w[2][7:0],  1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) mem_m[i] = w[i];
    check_done_cleared();
    for (int i = 0; i < 3; i++) bus_read(12'(i), "gapped_word");
  endtask

  task automatic test_wrap();
    logic [15:0] w;
    start_load();
    for (int i = 0; i < 4096; i++) begin
      w = 16'($urandom);
      mem_m[i] = w;
      send_byte(w[15:8], 1'b0, 1'b0, 1'b0);
      send_byte(w[7:0], 1'b0, 1'b0, i == 4095);
    end
    check_done_cleared();
    bus_read(12'h000, "wrap_first");
    bus_read(12'hFFD, "wrap_fffd");
    for (int i = 0; i < 12; i++) bus_read(12'($urandom_range(0, 4093)), "wrap_rand");
  endtask

  task automatic test_abort();
    logic [15:0] w;
    start_load();
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      mem_m[i] = w;
      send_byte(w[15:8], 1'b0, 1'b0, 1'b0);
      send_byte(w[7:0], 1'b0, 1'b0, 1'b0);
    end
    send_byte(8'hAB, 1'b0, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || ld_done !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort busy/done/ready got=%b%b%b want=000", busy, ld_done, ld_ready);
    end
    io_m = 16'h0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (ld_done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_done done/busy got=%b%b want=00", ld_done, busy);
      end
    end
    for (int i = 0; i < 4; i++) bus_read(12'(i), "abort_word");
    bus_read(12'hFFF, "abort_io_out");
  endtask

  initial begin
    reset = 1'b1;
    m_addr = '0; m_data = '0; m_wren = 1'b0; io_in = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    io_m = '0;
    for (int i = 0; i < 4096; i++) mem_m[i] = '0;
    test_reset();
    test_ram();
    test_io();
    test_random_bus();
    test_load();
    test_gapped_load();
    test_wrap();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
